// File: rtl/pwm_duty_sequencer_if.sv
// Target handshake between the duty-setting source and the PWM duty sequencer.
interface pwm_duty_sequencer_if #(
   parameter int unsigned DUTY_W = 4
);
   logic              tgt_valid;
   logic [DUTY_W-1:0] tgt_duty;
   logic              tgt_ready;

   modport master (output tgt_valid, output tgt_duty, input  tgt_ready);
   modport slave  (input  tgt_valid, input  tgt_duty, output tgt_ready);
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Rate-limited duty-cycle sequencer for the 10-step PWM generator.
// Ramps duty toward an absolute target (valid/ready) or by +1/-1 requests;
// duty only changes on PWM period boundaries.
module pwm_duty_sequencer #(
   parameter int unsigned DUTY_W    = 4,
   parameter int unsigned DUTY_MAX  = 10,
   parameter int unsigned DUTY_INIT = 5,
   parameter int unsigned STEP_DIV  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic                      period_wrap,
   input  logic                      inc_pulse,
   input  logic                      dec_pulse,
   pwm_duty_sequencer_if.slave       tgt,
   output logic [DUTY_W-1:0]         duty,
   output logic                      busy,
   output logic                      clamp_err
);

   localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DUTY_W-1:0] D_MAX  = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] D_INIT = DUTY_W'(DUTY_INIT);
   localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RAMP_UP = 2'd1,
      RAMP_DN = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [DUTY_W-1:0] target, target_nxt, duty_nxt, tgt_clamped;
   logic [CNT_W-1:0]  div_cnt, cnt_nxt;
   logic              clamp_nxt;

   // State, duty, target, divider and clamp flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         duty      <= D_INIT;
         target    <= D_INIT;
         div_cnt   <= '0;
         clamp_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         duty      <= duty_nxt;
         target    <= target_nxt;
         div_cnt   <= cnt_nxt;
         clamp_err <= clamp_nxt;
      end
   end

   // Next-state, datapath updates and handshake outputs
   always_comb begin
      state_nxt     = state;
      duty_nxt      = duty;
      target_nxt    = target;
      cnt_nxt       = div_cnt;
      clamp_nxt     = 1'b0;
      tgt_clamped   = (tgt.tgt_duty > D_MAX) ? D_MAX : tgt.tgt_duty;
      tgt.tgt_ready = ena && (state == IDLE);
      busy          = (state != IDLE);

      if (ena) begin
         unique case (state)
            IDLE: begin
               if (tgt.tgt_valid) begin
                  target_nxt = tgt_clamped;
                  clamp_nxt  = (tgt.tgt_duty > D_MAX);
                  cnt_nxt    = '0;
                  if (tgt_clamped > duty)      state_nxt = RAMP_UP;
                  else if (tgt_clamped < duty) state_nxt = RAMP_DN;
               end else if (inc_pulse && !dec_pulse && (duty != D_MAX)) begin
                  // Preloaded divider: the single step lands on the next wrap
                  target_nxt = duty + 1'b1;
                  cnt_nxt    = C_LAST;
                  state_nxt  = RAMP_UP;
               end else if (dec_pulse && !inc_pulse && (duty != '0)) begin
                  target_nxt = duty - 1'b1;
                  cnt_nxt    = C_LAST;
                  state_nxt  = RAMP_DN;
               end
            end
            RAMP_UP, RAMP_DN: begin
               if (period_wrap) begin
                  if (div_cnt == C_LAST) begin
                     cnt_nxt  = '0;
                     duty_nxt = (state == RAMP_UP) ? duty + 1'b1 : duty - 1'b1;
                     if (duty_nxt == target) state_nxt = IDLE;
                  end else begin
                     cnt_nxt = div_cnt + 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
